// File: rtl/mul4_seq_if.sv
// Operand/result bundle for the sequential 4x4 multiplier.
// master drives operands and start; slave returns busy, done and the product.
interface mul4_seq_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mul4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier: 4 cycles from start acceptance to done pulse.
// No backpressure: start is sampled only in IDLE; a new start may be accepted in the done cycle.

module fa4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[4];
endmodule

module mul4_seq (
    input  logic       clk,
    input  logic       rst_n,
    mul4_seq_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] m;
    logic [3:0] acc;
    logic [3:0] q;
    logic [1:0] cnt;
    logic       busy_q;
    logic       done_q;
    logic [7:0] product_q;

    logic [3:0] addend;
    logic [3:0] sum;
    logic       cout;

    // Add the multiplicand only when the current multiplier LSB is set.
    assign addend = q[0] ? m : 4'b0000;

    fa4 u_fa4 (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            m         <= 4'h0;
            acc       <= 4'h0;
            q         <= 4'h0;
            cnt       <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m      <= bus.a;
                        q      <= bus.b;
                        acc    <= 4'h0;
                        cnt    <= 2'd0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // {acc, q} <= {cout, sum, q} >> 1; q[0] is consumed and dropped.
                    acc <= {cout, sum[3:1]};
                    q   <= {sum[0], q[3:1]};
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        product_q <= {cout, sum, q[3:1]};
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_mul4_seq.sv
// Scoreboard bench for mul4_seq: stimulus queues expected products, a negedge monitor checks them.
module tb_mul4_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [7:0] sb[$];
    logic [7:0] exp_hold;

    mul4_seq_if bus ();

    mul4_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected product per done pulse and checks product holds otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_hold = 8'h00;
            chk("reset_product", int'(bus.product), 0);
        end else if (bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_hold = sb.pop_front();
                chk("product", int'(bus.product), int'(exp_hold));
                chk("busy_in_done", int'(bus.busy), 0);
            end
        end else begin
            chk("product_hold", int'(bus.product), int'(exp_hold));
        end
    end

    // Caller is at posedge+#1 with the DUT idle (or in its done cycle).
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic [7:0] exp, input bit noise);
        int lat;
        int busy_cnt;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        sb.push_back(exp);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = 4'($urandom);
        bus.b     = 4'($urandom);
        lat       = 0;
        busy_cnt  = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cnt++;
            if (noise) begin
                bus.start = 1'($urandom);
                bus.a     = 4'($urandom);
                bus.b     = 4'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        chk("latency", lat, 4);
        chk("busy_cycles", busy_cnt, 4);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_hold  = 8'h00;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 4'h0;
        bus.b     = 4'h0;
        #2;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_product", int'(bus.product), 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(4'hD, 4'hB, 8'h8F, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_8f", int'(bus.product), 8'h8F);

        run_op(4'hF, 4'hF, 8'hE1, 1'b1);
        run_op(4'h0, 4'h9, 8'h00, 1'b0);
        run_op(4'h7, 4'h0, 8'h00, 1'b1);

        // Back-to-back with start held high: second operands are taken at edge k+5.
        bus.start = 1'b1;
        bus.a     = 4'h3;
        bus.b     = 4'h5;
        sb.push_back(8'h0F);
        @(posedge clk); #1;
        bus.a = 4'h2;
        bus.b = 4'h6;
        sb.push_back(8'h0C);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 5) bus.start = 1'b0;
            chk("b2b_done", int'(bus.done), int'(cyc == 4 || cyc == 9));
        end

        // Reset in the middle of a 9*9 operation.
        bus.start = 1'b1;
        bus.a     = 4'h9;
        bus.b     = 4'h9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_product", int'(bus.product), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            chk("no_done_after_rst", int'(bus.done), 0);
        end
        run_op(4'h9, 4'h9, 8'h51, 1'b0);

        for (int i = 0; i < 256; i++) begin
            logic [3:0] sa;
            logic [3:0] sb_op;
            sa    = 4'(i >> 4);
            sb_op = 4'(i);
            run_op(sa, sb_op, 8'(int'(sa) * int'(sb_op)), 1'b0);
        end

        @(negedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
